seg_display_scheduler: RTL and testbench

- Decides what the 4-digit seven-segment display shows and formats each frame as per-digit character codes for the display driver.
- Shares the display between three sources: live temperature, operator setpoint feedback and alarm messages.
- Applies priority, dwell/hold timing and alarm blink.
- Contains a sequential binary-to-BCD engine, so committed frames are always consistent across all four digits.

---
 rtl/seg_display_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_seg_display_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// Display scheduler for a 4-digit seven-segment panel: arbitrates temperature,
// setpoint and alarm frames, then formats each one through a serial binary-to-BCD engine.
module seg_display_scheduler #(
    parameter int TICK_DIV   = 100000,
    parameter int SETPT_HOLD = 3000,
    parameter int ROTATE     = 2000,
    parameter int BLINK      = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  temp_in,
    input  logic [7:0]  setpt_in,
    input  logic        setpt_req,
    input  logic        alarm_active,
    input  logic [3:0]  alarm_code,
    output logic [15:0] disp_code,
    output logic [3:0]  disp_dp,
    output logic [1:0]  src,
    output logic        frame_upd
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(SETPT_HOLD + 1);
    localparam int RW = $clog2(ROTATE + 1);
    localparam int BW = $clog2(BLINK + 1);

    typedef enum logic [1:0] {TEMP, SETPT, ALARM_MSG, ALARM_TEMP} state_t;

    state_t          state_q, state_d, snap_state;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [HW-1:0]   hold_q, hold_d;
    logic [RW-1:0]   rot_q, rot_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d, snap_blink;
    logic [7:0]      setpt_q, setpt_d, snap_val, bin_q;
    logic [3:0]      snap_code, step_q;
    logic [11:0]     bcd_q, adj;
    logic            busy_q, pend_q, start_req, start_now, commit, changed_q;
    logic [3:0]      h, t, o, d2, d1, f_dp;
    logic [15:0]     f_code;
    logic [1:0]      f_src;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 1'b1;
    end

    // Every alarm entry restarts the slot with the message visible.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        rot_d       = rot_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        setpt_d     = setpt_q;
        if (setpt_req) begin
            state_d = SETPT;
            hold_d  = HW'(SETPT_HOLD);
            setpt_d = setpt_in;
        end else if (tick) begin
            unique case (state_q)
                TEMP: if (alarm_active) begin
                    state_d = ALARM_MSG; rot_d = '0; blink_cnt_d = '0; blink_on_d = 1'b1;
                end
                SETPT: begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= HW'(1)) begin
                        if (alarm_active) begin
                            state_d = ALARM_MSG; rot_d = '0; blink_cnt_d = '0; blink_on_d = 1'b1;
                        end else begin
                            state_d = TEMP;
                        end
                    end
                end
                ALARM_MSG: begin
                    if (!alarm_active) begin
                        state_d = TEMP;
                    end else if (rot_q == RW'(ROTATE - 1)) begin
                        state_d = ALARM_TEMP; rot_d = '0;
                    end else begin
                        rot_d = rot_q + 1'b1;
                        if (blink_cnt_q == BW'(BLINK - 1)) begin
                            blink_cnt_d = '0; blink_on_d = ~blink_on_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                end
                ALARM_TEMP: begin
                    if (!alarm_active) begin
                        state_d = TEMP;
                    end else if (rot_q == RW'(ROTATE - 1)) begin
                        state_d = ALARM_MSG; rot_d = '0; blink_cnt_d = '0; blink_on_d = 1'b1;
                    end else begin
                        rot_d = rot_q + 1'b1;
                    end
                end
                default: state_d = TEMP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= TEMP;
            hold_q      <= '0;
            rot_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            setpt_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rot_q       <= rot_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            setpt_q     <= setpt_d;
        end
    end

    assign start_req = tick || (state_d != state_q);
    assign start_now = !busy_q && (start_req || pend_q);
    assign commit    = busy_q && (step_q == 4'd9);

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // The frame context is snapshotted at start so a commit never mixes two frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            step_q     <= '0;
            snap_state <= TEMP;
            snap_blink <= 1'b0;
            snap_code  <= '0;
            snap_val   <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
        end else if (start_now) begin
            busy_q     <= 1'b1;
            pend_q     <= 1'b0;
            step_q     <= '0;
            snap_state <= state_d;
            snap_blink <= blink_on_d;
            snap_code  <= alarm_code;
            snap_val   <= (state_d == SETPT) ? setpt_d : temp_in;
        end else if (busy_q) begin
            if (start_req) pend_q <= 1'b1;
            step_q <= step_q + 1'b1;
            if (step_q == 4'd0) begin
                bcd_q <= '0;
                bin_q <= snap_val;
            end else if (step_q <= 4'd8) begin
                bcd_q <= {adj[10:0], bin_q[7]};
                bin_q <= {bin_q[6:0], 1'b0};
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    always_comb begin
        h  = bcd_q[11:8];
        t  = bcd_q[7:4];
        o  = bcd_q[3:0];
        d2 = (h == 4'd0) ? 4'hF : h;
        d1 = (h == 4'd0 && t == 4'd0) ? 4'hF : t;
        f_code = 16'hFFFF;
        f_dp   = 4'b0000;
        f_src  = 2'd3;
        unique case (snap_state)
            TEMP:  begin f_code = {d2, d1, o, 4'hC}; f_src = 2'd0; end
            SETPT: begin f_code = {4'hD, d2, d1, o}; f_dp = 4'b1000; f_src = 2'd1; end
            ALARM_MSG: begin
                f_src = 2'd2;
                if (snap_blink)
                    f_code = {4'hA, 4'hB, 4'hF, (snap_code > 4'd9) ? 4'hB : snap_code};
            end
            ALARM_TEMP: begin f_code = {d2, d1, o, 4'hC}; f_dp = 4'b0001; f_src = 2'd0; end
            default: f_code = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_code <= 16'hFFFF;
            disp_dp   <= 4'b0000;
            src       <= 2'd3;
            changed_q <= 1'b0;
            frame_upd <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (commit) begin
                disp_code <= f_code;
                disp_dp   <= f_dp;
                src       <= f_src;
                changed_q <= (f_code != disp_code) || (f_dp != disp_dp) || (f_src != src);
            end
            frame_upd <= changed_q;
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: expected frames are queued with the
// stimulus and popped on every frame_upd pulse.
module tb_seg_display_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  temp_in = 8'd25;
    logic [7:0]  setpt_in = 8'd0;
    logic        setpt_req = 1'b0;
    logic        alarm_active = 1'b0;
    logic [3:0]  alarm_code = 4'd0;
    logic [15:0] disp_code;
    logic [3:0]  disp_dp;
    logic [1:0]  src;
    logic        frame_upd;

    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  dp;
        logic [1:0]  src;
    } frame_t;

    frame_t exp_q[$];
    int     upd_times[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    seg_display_scheduler #(.TICK_DIV(16), .SETPT_HOLD(4), .ROTATE(3), .BLINK(1)) dut (
        .clk(clk), .reset(reset), .temp_in(temp_in), .setpt_in(setpt_in),
        .setpt_req(setpt_req), .alarm_active(alarm_active), .alarm_code(alarm_code),
        .disp_code(disp_code), .disp_dp(disp_dp), .src(src), .frame_upd(frame_upd)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [15:0] code, input logic [3:0] dp, input logic [1:0] s);
        frame_t f;
        f.code = code; f.dp = dp; f.src = s;
        exp_q.push_back(f);
    endtask

    // One cycle of the scoreboard: any update pulse consumes the oldest expected frame.
    task automatic step();
        frame_t e;
        @(negedge clk);
        cyc++;
        if (!reset && frame_upd) begin
            upd_times.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_upd got code=%h dp=%b src=%0d, required no update",
                         disp_code, disp_dp, src);
            end else begin
                e = exp_q.pop_front();
                if ({disp_code, disp_dp, src} !== e) begin
                    errors++;
                    $display("[TB] FAIL frame got code=%h dp=%b src=%0d, required code=%h dp=%b src=%0d",
                             disp_code, disp_dp, src, e.code, e.dp, e.src);
                end
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s timeout got %0d frames pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_setpt(input logic [7:0] v);
        setpt_in  = v;
        setpt_req = 1'b1;
        step();
        setpt_req = 1'b0;
    endtask

    task automatic test_reset();
        int t0;
        step();
        step();
        #1;
        checks++;
        if (disp_code !== 16'hFFFF || disp_dp !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_code got %h/%b, required FFFF/0000", disp_code, disp_dp);
        end
        checks++;
        if (src !== 2'd3 || frame_upd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_src got src=%0d upd=%b, required src=3 upd=0", src, frame_upd);
        end
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        upd_times.delete();
        push(16'hF25C, 4'b0000, 2'd0);
        drain("first_frame", 40);
        checks++;
        if (upd_times.size() < 1 || upd_times[0] - t0 > 28) begin
            errors++;
            $display("[TB] FAIL first_latency got %0d updates, required first within 28 cycles",
                     upd_times.size());
        end
        repeat (48) step();
        checks++;
        if (upd_times.size() != 1) begin
            errors++;
            $display("[TB] FAIL static_no_pulse got %0d updates, required 1", upd_times.size());
        end
    endtask

    task automatic test_temp_sweep();
        logic [7:0]  vals [5] = '{8'd0, 8'd100, 8'd255, 8'd7, 8'd25};
        logic [15:0] exps [5] = '{16'hFF0C, 16'h100C, 16'h255C, 16'hFF7C, 16'hF25C};
        for (int i = 0; i < 5; i++) begin
            temp_in = vals[i];
            push(exps[i], 4'b0000, 2'd0);
            drain("temp_sweep", 40);
        end
    endtask

    task automatic test_setpt_hold();
        int r2;
        pulse_setpt(8'd42);
        push(16'hDF42, 4'b1000, 2'd1);
        drain("setpt_show", 40);
        repeat (32) step();
        pulse_setpt(8'd42);
        r2 = cyc;
        upd_times.delete();
        push(16'hF25C, 4'b0000, 2'd0);
        drain("setpt_return", 100);
        checks++;
        if (upd_times.size() != 1 || upd_times[0] - r2 < 60 || upd_times[0] - r2 > 75) begin
            errors++;
            $display("[TB] FAIL setpt_extend got %0d updates delay=%0d, required 1 update delay 60..75",
                     upd_times.size(), (upd_times.size() > 0) ? upd_times[0] - r2 : -1);
        end
    endtask

    task automatic test_alarm();
        int gaps [7] = '{16, 16, 16, 48, 16, 16, 16};
        upd_times.delete();
        alarm_code   = 4'd3;
        alarm_active = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(16'hABF3, 4'b0000, 2'd2);
            push(16'hFFFF, 4'b0000, 2'd2);
            push(16'hABF3, 4'b0000, 2'd2);
            push(16'hF25C, 4'b0001, 2'd0);
        end
        drain("alarm_rotate", 300);
        checks++;
        if (upd_times.size() != 8) begin
            errors++;
            $display("[TB] FAIL alarm_count got %0d updates, required 8", upd_times.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (upd_times[i+1] - upd_times[i] != gaps[i]) begin
                    errors++;
                    $display("[TB] FAIL alarm_gap%0d got %0d, required %0d",
                             i, upd_times[i+1] - upd_times[i], gaps[i]);
                end
            end
        end
        alarm_code = 4'd12;
        push(16'hABFB, 4'b0000, 2'd2);
        push(16'hFFFF, 4'b0000, 2'd2);
        push(16'hABFB, 4'b0000, 2'd2);
        push(16'hF25C, 4'b0001, 2'd0);
        drain("alarm_code12", 200);
        alarm_active = 1'b0;
        push(16'hF25C, 4'b0000, 2'd0);
        drain("alarm_drop", 40);
    endtask

    task automatic test_setpt_alarm_reset();
        int t0;
        alarm_code = 4'd3;
        upd_times.delete();
        alarm_active = 1'b1;
        pulse_setpt(8'd7);
        push(16'hDFF7, 4'b1000, 2'd1);
        push(16'hABF3, 4'b0000, 2'd2);
        push(16'hFFFF, 4'b0000, 2'd2);
        drain("setpt_alarm", 200);
        checks++;
        if (upd_times.size() != 3 || upd_times[1] - upd_times[0] < 49 ||
            upd_times[1] - upd_times[0] > 64 || upd_times[2] - upd_times[1] != 16) begin
            errors++;
            $display("[TB] FAIL setpt_alarm_timing got %0d updates, required 3 with hold 49..64 then 16",
                     upd_times.size());
        end
        repeat (7) step();
        reset = 1'b1;
        #1;
        checks++;
        if (disp_code !== 16'hFFFF || src !== 2'd3 || disp_dp !== 4'b0000 || frame_upd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midconv_reset got %h/%b/%0d upd=%b, required FFFF/0000/3 upd=0",
                     disp_code, disp_dp, src, frame_upd);
        end
        repeat (3) step();
        checks++;
        if (frame_upd !== 1'b0 || disp_code !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL held_reset got %h upd=%b, required FFFF upd=0", disp_code, frame_upd);
        end
        alarm_active = 1'b0;
        reset = 1'b0;
        t0 = cyc;
        upd_times.delete();
        push(16'hF25C, 4'b0000, 2'd0);
        drain("post_reset", 40);
        checks++;
        if (upd_times.size() < 1 || upd_times[0] - t0 > 28) begin
            errors++;
            $display("[TB] FAIL post_reset_latency got %0d updates, required first within 28 cycles",
                     upd_times.size());
        end
    endtask

    initial begin
        test_reset();
        test_temp_sweep();
        test_setpt_hold();
        test_alarm();
        test_setpt_alarm_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
